// File: rtl/sqrt_pkg.sv
// Shared constants and state encoding for the iterative shift-add squarer.
// FSM state values are kept as plain logic constants for legacy tool flows.
package sqrt_pkg;

    localparam int ROOT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W_DEF = $clog2(ROOT_W_DEF + 1);

    function automatic int cnt_width(input int root_w);
        return $clog2(root_w + 1);
    endfunction

endpackage

// File: rtl/sqrt_square_check_if.sv
// Start/busy/done handshake and operand/result bus of the squarer.
// The producer side uses the master modport, the squarer uses slave.
interface sqrt_square_check_if #(
    parameter int ROOT_W = sqrt_pkg::ROOT_W_DEF
) ();
    logic                  start;
    logic [ROOT_W-1:0]     root_in;
    logic [2*ROOT_W-1:0]   num_in;
    logic                  busy;
    logic                  done;
    logic [2*ROOT_W-1:0]   square;
    logic                  exact;
    logic                  floor_ok;

    modport master (
        output start, root_in, num_in,
        input  busy, done, square, exact, floor_ok
    );

    modport slave (
        input  start, root_in, num_in,
        output busy, done, square, exact, floor_ok
    );
endinterface

// File: rtl/sqrt_floor_cmp.sv
// Combinational check of a squared root against the original radicand.
// Upper bound (root+1)^2 = sq + 2*root + 1 is formed one bit wider so it cannot wrap.
module sqrt_floor_cmp #(
    parameter int ROOT_W = sqrt_pkg::ROOT_W_DEF
) (
    input  logic [2*ROOT_W-1:0] sq,
    input  logic [ROOT_W-1:0]   root,
    input  logic [2*ROOT_W-1:0] num,
    output logic                exact,
    output logic                floor_ok
);
    localparam int EXT_W = 2*ROOT_W + 1;

    logic [EXT_W-1:0] sq_ext;
    logic [EXT_W-1:0] num_ext;
    logic [EXT_W-1:0] root_ext;
    logic [EXT_W-1:0] upper;

    always_comb begin
        sq_ext   = {1'b0, sq};
        num_ext  = {1'b0, num};
        root_ext = {{(ROOT_W + 1){1'b0}}, root};
        upper    = sq_ext + (root_ext << 1) + {{(EXT_W - 1){1'b0}}, 1'b1};
        exact    = (sq == num);
        floor_ok = (sq_ext <= num_ext) && (num_ext < upper);
    end
endmodule

// File: rtl/sqrt_square_check.sv
// Iterative shift-add squarer: root*root in ROOT_W cycles with start/busy/done handshake.
// Define SQRT_FLOOR_CHECK_EN to also compare the square against the latched radicand.
module sqrt_square_check
    import sqrt_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    sqrt_square_check_if.slave bus
);
    localparam int SQ_W  = 2*ROOT_W;
    localparam int CNT_W = cnt_width(ROOT_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROOT_W - 1);

    logic [1:0]        state_q, state_d;
    logic [ROOT_W-1:0] mcand_q, mcand_d;
    logic [ROOT_W-1:0] mplier_q, mplier_d;
    logic [SQ_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SQ_W-1:0]   square_q, square_d;
    logic              exact_q, exact_d;
    logic              floor_ok_q, floor_ok_d;

    logic              accept;
    logic [SQ_W-1:0]   addend;
    logic [SQ_W-1:0]   acc_step;
    logic              chk_exact;
    logic              chk_floor;

`ifdef SQRT_FLOOR_CHECK_EN
    logic [SQ_W-1:0] num_q, num_d;

    always_comb num_d = accept ? bus.num_in : num_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) num_q <= '0;
        else     num_q <= num_d;
    end

    // acc_step is the final product on the last RUN cycle, so it is checked directly.
    sqrt_floor_cmp #(.ROOT_W(ROOT_W)) u_floor_cmp (
        .sq       (acc_step),
        .root     (mcand_q),
        .num      (num_q),
        .exact    (chk_exact),
        .floor_ok (chk_floor)
    );
`else
    assign chk_exact = 1'b0;
    assign chk_floor = 1'b0;
`endif

    always_comb begin
        accept     = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        addend     = {{ROOT_W{1'b0}}, mcand_q} << cnt_q;
        acc_step   = mplier_q[0] ? (acc_q + addend) : acc_q;

        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        square_d   = square_q;
        exact_d    = exact_q;
        floor_ok_d = floor_ok_q;

        case (state_q)
            ST_RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d    = ST_DONE;
                    square_d   = acc_step;
                    exact_d    = chk_exact;
                    floor_ok_d = chk_floor;
                end
            end
            default: begin
                // IDLE and DONE accept identically, which gives back-to-back runs.
                if (accept) begin
                    state_d    = ST_RUN;
                    mcand_d    = bus.root_in;
                    mplier_d   = bus.root_in;
                    acc_d      = '0;
                    cnt_d      = '0;
                    square_d   = '0;
                    exact_d    = 1'b0;
                    floor_ok_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            square_q   <= '0;
            exact_q    <= 1'b0;
            floor_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            square_q   <= square_d;
            exact_q    <= exact_d;
            floor_ok_q <= floor_ok_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.square   = square_q;
    assign bus.exact    = exact_q;
    assign bus.floor_ok = floor_ok_q;
endmodule

// File: tb/tb_sqrt_square_check.sv
// Scoreboard bench for sqrt_square_check: expectations queued at start, compared on done.
// Expected exact/floor_ok follow SQRT_FLOOR_CHECK_EN the same way the design build does.
module tb_sqrt_square_check;
    localparam int RW = 8;

    typedef struct {
        logic [2*RW-1:0] sq;
        logic            ex;
        logic            fl;
        int              at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    sqrt_square_check_if #(.ROOT_W(RW)) bus ();

    sqrt_square_check #(.ROOT_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int r, input int n, input int at);
        exp_t e;
        int   sq;
        sq   = r * r;
        e.sq = sq[2*RW-1:0];
`ifdef SQRT_FLOOR_CHECK_EN
        e.ex = (sq == n);
        e.fl = (sq <= n) && (n < (r + 1) * (r + 1));
`else
        e.ex = 1'b0;
        e.fl = 1'b0;
`endif
        e.at = at;
        return e;
    endfunction

    // Output monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("square", 32'(bus.square), 32'(e.sq));
                check_val("exact", 32'(bus.exact), 32'(e.ex));
                check_val("floor_ok", 32'(bus.floor_ok), 32'(e.fl));
                check_val("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic drive_start(input int r, input int n, output int k);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.root_in = RW'(r);
        bus.num_in  = (2*RW)'(n);
        @(posedge clk);
        #1;
        k = cyc;
        sb.push_back(model(r, n, k + RW));
        bus.start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_val(tag, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_cycle(input int target);
        int n = 0;
        while (cyc < target && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (cyc < target) check_val("wait_timeout", 32'(cyc), 32'(target));
    endtask

    task automatic run_op(input int r, input int n);
        int k;
        drive_start(r, n, k);
        for (int i = 0; i < RW; i++) begin
            @(negedge clk);
            check_val("busy_run", 32'(bus.busy), 32'd1);
            if (i == 3) check_val("square_clr_run", 32'(bus.square), 32'd0);
        end
        drain("done_timeout");
        repeat (3) @(negedge clk);
        check_val("square_held", 32'(bus.square), 32'(r * r));
        check_val("done_low_after", 32'(bus.done), 32'd0);
        check_val("busy_low_after", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int k;
        int d0;
        bus.start   = 1'b0;
        bus.root_in = '0;
        bus.num_in  = '0;

        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_square", 32'(bus.square), 32'd0);
        check_val("rst_exact", 32'(bus.exact), 32'd0);
        check_val("rst_floor", 32'(bus.floor_ok), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(255, 65535);
        run_op(0, 5);
        run_op(1, 1);
        run_op(16, 256);
        run_op(12, 144);
        run_op(11, 100);

        // start pulsed mid-run must be ignored
        d0 = done_cnt;
        drive_start(100, 0, k);
        wait_cycle(k + 2);
        bus.start   = 1'b1;
        bus.root_in = RW'(7);
        @(negedge clk);
        bus.start = 1'b0;
        drain("ignored_timeout");
        repeat (12) @(negedge clk);
        check_val("ignored_square", 32'(bus.square), 32'd10000);
        check_val("ignored_done_cnt", 32'(done_cnt), 32'(d0 + 1));

        // start held through DONE: second run starts with no IDLE gap
        drive_start(9, 81, k);
        bus.start = 1'b1;
        @(negedge clk);
        bus.root_in = RW'(12);
        bus.num_in  = (2*RW)'(144);
        wait_cycle(k + RW + 1);
        sb.push_back(model(12, 144, k + 2*RW + 1));
        bus.start = 1'b0;
        check_val("b2b_busy", 32'(bus.busy), 32'd1);
        drain("b2b_timeout");
        @(negedge clk);
        check_val("b2b_square", 32'(bus.square), 32'd144);

        // asynchronous reset in the middle of a run
        d0 = done_cnt;
        drive_start(200, 0, k);
        wait_cycle(k + 4);
        rst = 1'b1;
        #1;
        check_val("midrst_busy", 32'(bus.busy), 32'd0);
        check_val("midrst_done", 32'(bus.done), 32'd0);
        check_val("midrst_square", 32'(bus.square), 32'd0);
        check_val("midrst_exact", 32'(bus.exact), 32'd0);
        check_val("midrst_floor", 32'(bus.floor_ok), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_val("midrst_no_done", 32'(done_cnt), 32'(d0));
        check_val("midrst_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sqrt_square_check.md
Name: sqrt_square_check

Overview:
- Iterative shift-add squarer: the inverse-direction companion to the iterative square-root unit.
- Takes a candidate root (and the original radicand) and computes root*root over ROOT_W cycles.
- Sits downstream of the sqrt unit as a result checker, or stand-alone as a small-area squarer.
- Uses a start/busy/done handshake so it can be chained to any iterative producer.

Parameters:
- ROOT_W, 8, width of root operand; square and radicand widths are 2*ROOT_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled at rising clk edge, accepted only in IDLE or DONE
- root_in  input  ROOT_W  candidate root, latched on accepted start
- num_in  input  2*ROOT_W  radicand, latched on accepted start (used only by optional feature)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when square valid
- square  output  2*ROOT_W  root_in squared; held until next accepted start
- exact  output  1  square == latched num (optional feature)
- floor_ok  output  1  square <= num < (root+1)^2 (optional feature)

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; busy=0, done=0, square=0, exact=0, floor_ok=0.
  - Internal accumulator, operand registers and bit counter are cleared.
- State IDLE:
  - start=1 -> latch root_in into mcand and mplier, latch num_in, clear acc, cnt=0, go RUN.
- State RUN (busy=1), one iteration per cycle:
  - If mplier[0] then acc <= acc + (mcand << cnt).
  - mplier >>= 1; cnt++.
  - After exactly ROOT_W RUN cycles go DONE.
- State DONE (done=1 for this one cycle):
  - square <= acc is registered on the RUN->DONE edge.
  - start=1 in DONE -> accepted exactly as in IDLE (back-to-back); otherwise go IDLE.
- Latency:
  - start accepted at edge k -> busy high for cycles k..k+ROOT_W-1.
  - done high in cycle k+ROOT_W, with square valid in the same cycle.
- start while busy=1 is ignored; operands are not re-latched and no error is flagged.
- Arithmetic:
  - acc is 2*ROOT_W bits; max (2^ROOT_W-1)^2 fits, so no overflow is possible.
  - Shifted addend is zero-extended.
- root_in=0 -> acc stays 0; still takes the full ROOT_W cycles (fixed latency, no early exit).
- square, exact and floor_ok are held stable from done until the edge after the next accepted start.
  - They then clear to 0 for the duration of RUN.
- Reset asserted mid-RUN: immediate return to IDLE, all outputs 0, and no done pulse.

Optional Feature:
- Macro: SQRT_FLOOR_CHECK_EN.
- Defined: computed in DONE, registered alongside square.
  - exact = (acc == num).
  - floor_ok = (acc <= num) && (num < acc + 2*root + 1), evaluated at 2*ROOT_W+1 bits to avoid wrap.
- Undefined: exact and floor_ok are tied 0; num_in is unused and not latched; the ports remain present.

Decomposition:
- Package sqrt_pkg holds:
  - ROOT_W default constant.
  - State enum {IDLE, RUN, DONE}.
  - Counter width localparam $clog2(ROOT_W+1).
- One natural sub-module, sqrt_floor_cmp:
  - Combinational exact/floor_ok compare.
  - Instantiated only under SQRT_FLOOR_CHECK_EN.

Test Plan:
- Reset, then start with root_in=255 -> busy 8 cycles; done pulse in cycle k+8 with square=65025; held after done.
- root_in=0 -> done at k+8, square=0. root_in=1 -> square=1. root_in=16 -> square=256.
- Start pulsed again 3 cycles into RUN with root_in=7 -> ignored; result is square of original operand; done still at k+8.
- Back-to-back: start held high through DONE with root_in=12 -> second run begins without IDLE; square=144 at k+17.
- rst asserted at cycle k+4 of RUN -> busy=0, done=0, square=0 immediately; no done pulse afterwards.
- With SQRT_FLOOR_CHECK_EN:
  - num=65535, root=255 -> floor_ok=1, exact=0.
  - num=144, root=12 -> exact=1, floor_ok=1.
  - num=100, root=11 -> floor_ok=0.
  - Without the macro, all three cases give floor_ok=0 and exact=0.
